button_conditioner: RTL

//  Front-end for the washing_machine controller: synchronises, debounces and

---
 rtl/button_conditioner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Button front-end: sync, debounce and press-pulse for four panel buttons.
// Optional mode/stage auto-repeat is built only when BTN_REPEAT_EN is defined.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   power/pause/mode/stage_raw  raw active-high buttons (asynchronous)
//   power/pause/mode/stage_button  one-cycle press pulses
//   btn_level[3:0]           debounced levels {power,pause,mode,stage}
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_raw,
  input  logic       pause_raw,
  input  logic       mode_raw,
  input  logic       stage_raw,
  output logic       power_button,
  output logic       pause_button,
  output logic       mode_button,
  output logic       stage_button,
  output logic [3:0] btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_params
    $error("button_conditioner: illegal parameters");
  end

  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    stable;
  logic [3:0]    stable_nxt;
  logic [3:0]    pulse;
  logic [3:0]    pulse_nxt;
  logic [3:0]    rep_hit;
  logic [CW-1:0] cnt     [4];
  logic [CW-1:0] cnt_nxt [4];

  assign raw = {power_raw, pause_raw, mode_raw, stage_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      pulse  <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= stable_nxt;
      pulse  <= pulse_nxt;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Count consecutive mismatches; the count never passes CNT_LAST
  // because reaching it either accepts the level or gets cleared.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt[i];
      if (s2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable_nxt[i] = s2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  assign pulse_nxt = (stable_nxt & ~stable) | rep_hit;

`ifdef BTN_REPEAT_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RELOAD    =
    HW'(HOLD_CYCLES - REPEAT_CYCLES);

  // Hold timers for mode (1) and stage (0) only.
  logic [HW-1:0] hold     [2];
  logic [HW-1:0] hold_nxt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold[0] <= '0;
      hold[1] <= '0;
    end else begin
      hold[0] <= hold_nxt[0];
      hold[1] <= hold_nxt[1];
    end
  end

  // Timer is 0 in the cycle after the press edge; hitting
  // HOLD_LAST fires a repeat and reloads so the next one is
  // REPEAT_CYCLES later.
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < 2; i++) begin
      hold_nxt[i] = hold[i];
      if (!stable[i]) begin
        hold_nxt[i] = '0;
      end else if (hold[i] == HOLD_LAST) begin
        rep_hit[i]  = 1'b1;
        hold_nxt[i] = RELOAD;
      end else begin
        hold_nxt[i] = hold[i] + HW'(1);
      end
    end
  end
`else
  assign rep_hit = '0;
`endif

  assign {power_button, pause_button,
          mode_button, stage_button} = pulse;
  assign btn_level = stable;

endmodule
